// File: rtl/vc_out_alloc_ctrl_pkg.sv
// Shared definitions for the VC output allocator: width helper, FSM encoding,
// and requester index mapping.
package vc_out_alloc_ctrl_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Ceiling log2 with a minimum of one bit so single-entry vectors still index.
    function automatic int unsigned log2_ceil(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) width++;
        return width;
    endfunction

    // Flattened requester index for a given input port and virtual channel.
    function automatic int unsigned req_index(input int unsigned port,
                                              input int unsigned vc,
                                              input int unsigned num_vc);
        return port * num_vc + vc;
    endfunction

endpackage

// File: rtl/vc_out_alloc_ctrl_rr_pick_core.sv
// Round-robin first-eligible picker: rotate by token, take the lowest set bit,
// rotate the winner back to an absolute index.
module rr_pick_core #(
    parameter int unsigned N  = 5,
    parameter int unsigned IW = 3
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] token,
    output logic [N-1:0]  pick_vec,
    output logic [IW-1:0] pick_idx,
    output logic          pick_any
);

    logic [N-1:0]  rotated;
    logic [IW:0]   src;
    logic [IW:0]   back;
    logic [IW-1:0] offset;
    logic          found;

    // Rotate, priority-select, and rotate back in one combinational pass.
    always_comb begin
        rotated  = '0;
        src      = '0;
        back     = '0;
        offset   = '0;
        found    = 1'b0;
        pick_vec = '0;
        pick_idx = '0;
        pick_any = 1'b0;

        for (int i = 0; i < int'(N); i++) begin
            src = {1'b0, token} + (IW+1)'(i);
            if (src >= (IW+1)'(N)) src = src - (IW+1)'(N);
            rotated[i] = eligible[IW'(src)];
        end

        for (int i = 0; i < int'(N); i++) begin
            if (!found && rotated[i]) begin
                found  = 1'b1;
                offset = IW'(i);
            end
        end

        back = {1'b0, token} + {1'b0, offset};
        if (back >= (IW+1)'(N)) back = back - (IW+1)'(N);
        pick_idx = IW'(back);
        if (found) pick_vec[pick_idx] = 1'b1;
        pick_any = found;
    end

endmodule

// File: rtl/vc_out_alloc_ctrl.sv
// Output-port VC allocator with wormhole locking and per-VC credit tracking.
// Optional lock watchdog is built when VC_OUT_ALLOC_TIMEOUT_EN is defined.
module vc_out_alloc_ctrl
    import vc_out_alloc_ctrl_pkg::*;
#(
    parameter int unsigned NUM_VC         = 1,
    parameter int unsigned NUM_VN         = 3,
    parameter int unsigned NUM_PORTS      = 5,
    parameter int unsigned CREDITS        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                                     clk,
    input  logic                                     rst_p,
    input  logic [NUM_PORTS*NUM_VC-1:0]              req_in,
    input  logic [NUM_PORTS*NUM_VC-1:0]              tail_in,
    input  logic [NUM_VC-1:0]                        credit_inc,
    output logic [NUM_PORTS*NUM_VC-1:0]              grant_vec,
    output logic [log2_ceil(NUM_PORTS*NUM_VC)-1:0]   grant_id,
    output logic                                     grant_valid,
    output logic                                     xfer,
    output logic [NUM_VC-1:0]                        credit_ok,
    output logic                                     timeout_err
);

    localparam int unsigned NUM_REQ = NUM_PORTS * NUM_VC;
    localparam int unsigned ID_W    = log2_ceil(NUM_REQ);
    localparam int unsigned VC_W    = log2_ceil(NUM_VC);
    localparam int unsigned CNT_W   = log2_ceil(CREDITS + 1);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [ID_W-1:0]     token_q, token_d;
    logic [NUM_REQ-1:0]  grant_vec_q, grant_vec_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic                grant_valid_q, grant_valid_d;

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  pick_vec;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_any;
    logic [ID_W-1:0]     owner_inc;
    logic [VC_W-1:0]     owner_vc;
    logic                timeout_hit;

    // A requester is eligible only if its downstream VC has a free slot.
    for (genvar p = 0; p < int'(NUM_PORTS); p++) begin : g_port
        for (genvar v = 0; v < int'(NUM_VC); v++) begin : g_req
            assign eligible[req_index(p, v, NUM_VC)] =
                req_in[req_index(p, v, NUM_VC)] & credit_ok[v];
        end
    end

    rr_pick_core #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .eligible (eligible),
        .token    (token_q),
        .pick_vec (pick_vec),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

    assign owner_vc  = VC_W'(32'(owner_q) % 32'(NUM_VC));
    assign owner_inc = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);
    assign xfer      = grant_valid_q && req_in[owner_q] && credit_ok[owner_vc];

    // Per-VC credit counters: +1 on return, -1 on a flit sent, saturating at CREDITS.
    for (genvar v = 0; v < int'(NUM_VC); v++) begin : g_vc
        logic [CNT_W-1:0] cnt_q;
        logic             dec;

        assign dec          = xfer && (owner_vc == VC_W'(v));
        assign credit_ok[v] = (cnt_q != '0);

        // Credit count update; simultaneous return and send cancel out.
        always_ff @(posedge clk or posedge rst_p) begin
            if (rst_p) begin
                cnt_q <= CNT_W'(CREDITS);
            end else if (credit_inc[v] && !dec) begin
                if (cnt_q != CNT_W'(CREDITS)) cnt_q <= cnt_q + CNT_W'(1);
            end else if (!credit_inc[v] && dec) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Arbitrate in IDLE; hold the wormhole lock until the tail moves or the watchdog fires.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        token_d       = token_q;
        grant_vec_d   = grant_vec_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d       = ST_LOCKED;
                    owner_d       = pick_idx;
                    grant_vec_d   = pick_vec;
                    grant_id_d    = pick_idx;
                    grant_valid_d = 1'b1;
                end
            end
            ST_LOCKED: begin
                if ((xfer && tail_in[owner_q]) || timeout_hit) begin
                    state_d       = ST_IDLE;
                    token_d       = owner_inc;
                    grant_vec_d   = '0;
                    grant_id_d    = '0;
                    grant_valid_d = 1'b0;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                grant_vec_d   = '0;
                grant_id_d    = '0;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    // FSM, ownership and grant output registers.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            token_q       <= '0;
            grant_vec_q   <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            token_q       <= token_d;
            grant_vec_q   <= grant_vec_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    assign grant_vec   = grant_vec_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;

`ifdef VC_OUT_ALLOC_TIMEOUT_EN
    localparam int unsigned WD_W = log2_ceil(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q;
    logic            timeout_err_q;
    logic            unused_cfg;

    assign unused_cfg  = ^{32'(NUM_VN)};
    assign timeout_hit = grant_valid_q && !xfer && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Count stalled locked cycles; fire a one-cycle error when the limit is reached.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_hit;
            if (!grant_valid_q || xfer || timeout_hit) wd_q <= '0;
            else                                        wd_q <= wd_q + WD_W'(1);
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_cfg;

    assign unused_cfg  = ^{32'(NUM_VN), 32'(TIMEOUT_CYCLES)};
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_vc_out_alloc_ctrl.sv
// Directed bench for vc_out_alloc_ctrl with NUM_VC=2, NUM_PORTS=5, CREDITS=4.
module tb_vc_out_alloc_ctrl;

    logic       clk = 1'b0;
    logic       rst_p;
    logic [9:0] req_in;
    logic [9:0] tail_in;
    logic [1:0] credit_inc;
    logic [9:0] grant_vec;
    logic [3:0] grant_id;
    logic       grant_valid;
    logic       xfer;
    logic [1:0] credit_ok;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    vc_out_alloc_ctrl #(
        .NUM_VC         (2),
        .NUM_VN         (3),
        .NUM_PORTS      (5),
        .CREDITS        (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_p       (rst_p),
        .req_in      (req_in),
        .tail_in     (tail_in),
        .credit_inc  (credit_inc),
        .grant_vec   (grant_vec),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .xfer        (xfer),
        .credit_ok   (credit_ok),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_time_limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_p = 1'b1; req_in = '0; tail_in = '0; credit_inc = '0;
        tick(); tick();
        rst_p = 1'b0;
    endtask

    task automatic test_reset();
        rst_p = 1'b1; req_in = '0; tail_in = '0; credit_inc = '0;
        tick();
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", grant_valid); end
        checks++; if (grant_id !== 4'd0) begin errors++; $display("FAIL rst_id got %0d exp 0", grant_id); end
        checks++; if (grant_vec !== 10'd0) begin errors++; $display("FAIL rst_vec got %h exp 0", grant_vec); end
        checks++; if (credit_ok !== 2'b11) begin errors++; $display("FAIL rst_credit_ok got %b exp 11", credit_ok); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout got %0b exp 0", timeout_err); end
        checks++; if (dut.g_vc[0].cnt_q !== 3'd4) begin errors++; $display("FAIL rst_cnt0 got %0d exp 4", dut.g_vc[0].cnt_q); end
        rst_p = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        req_in = 10'b0010001000; tail_in = 10'b0010001000;
        tick();
        checks++; if (grant_id !== 4'd3 || grant_valid !== 1'b1) begin errors++; $display("FAIL rr_first got id %0d v %0b exp id 3 v 1", grant_id, grant_valid); end
        checks++; if (grant_vec !== 10'h008) begin errors++; $display("FAIL rr_first_vec got %h exp 008", grant_vec); end
        checks++; if (xfer !== 1'b1) begin errors++; $display("FAIL rr_first_xfer got %0b exp 1", xfer); end
        tick();
        checks++; if (grant_valid !== 1'b0 || grant_id !== 4'd0) begin errors++; $display("FAIL rr_bubble got v %0b id %0d exp v 0 id 0", grant_valid, grant_id); end
        checks++; if (dut.token_q !== 4'd4) begin errors++; $display("FAIL rr_token4 got %0d exp 4", dut.token_q); end
        req_in[3] = 1'b0; tail_in[3] = 1'b0;
        tick();
        checks++; if (grant_id !== 4'd7 || grant_vec !== 10'h080) begin errors++; $display("FAIL rr_second got id %0d vec %h exp id 7 vec 080", grant_id, grant_vec); end
        tick();
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rr_release got %0b exp 0", grant_valid); end
        checks++; if (dut.token_q !== 4'd8) begin errors++; $display("FAIL rr_token8 got %0d exp 8", dut.token_q); end
        checks++; if (dut.g_vc[1].cnt_q !== 3'd2) begin errors++; $display("FAIL rr_cnt1 got %0d exp 2", dut.g_vc[1].cnt_q); end
        req_in = '0; tail_in = '0;
    endtask

    task automatic test_wormhole();
        do_reset();
        req_in[4] = 1'b1; tail_in[4] = 1'b0;
        tick();
        checks++; if (grant_id !== 4'd4) begin errors++; $display("FAIL wh_grant got %0d exp 4", grant_id); end
        req_in[1] = 1'b1; tail_in[1] = 1'b1;
        #1;
        checks++; if (xfer !== 1'b1) begin errors++; $display("FAIL wh_flit1_xfer got %0b exp 1", xfer); end
        tick();
        checks++; if (grant_id !== 4'd4 || grant_valid !== 1'b1) begin errors++; $display("FAIL wh_hold1 got id %0d v %0b exp id 4 v 1", grant_id, grant_valid); end
        req_in[4] = 1'b0;
        #1;
        checks++; if (xfer !== 1'b0) begin errors++; $display("FAIL wh_stall_xfer got %0b exp 0", xfer); end
        tick();
        checks++; if (grant_id !== 4'd4 || grant_valid !== 1'b1) begin errors++; $display("FAIL wh_stall_hold got id %0d v %0b exp id 4 v 1", grant_id, grant_valid); end
        req_in[4] = 1'b1;
        #1;
        checks++; if (xfer !== 1'b1) begin errors++; $display("FAIL wh_flit2_xfer got %0b exp 1", xfer); end
        tick();
        checks++; if (grant_id !== 4'd4) begin errors++; $display("FAIL wh_hold2 got %0d exp 4", grant_id); end
        tail_in[4] = 1'b1;
        tick();
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL wh_bubble got %0b exp 0", grant_valid); end
        checks++; if (dut.token_q !== 4'd5) begin errors++; $display("FAIL wh_token got %0d exp 5", dut.token_q); end
        req_in[4] = 1'b0; tail_in[4] = 1'b0;
        tick();
        checks++; if (grant_id !== 4'd1 || grant_valid !== 1'b1) begin errors++; $display("FAIL wh_next got id %0d v %0b exp id 1 v 1", grant_id, grant_valid); end
        checks++; if (dut.g_vc[0].cnt_q !== 3'd1) begin errors++; $display("FAIL wh_cnt0 got %0d exp 1", dut.g_vc[0].cnt_q); end
        tick();
        checks++; if (dut.g_vc[1].cnt_q !== 3'd3) begin errors++; $display("FAIL wh_cnt1 got %0d exp 3", dut.g_vc[1].cnt_q); end
        req_in = '0; tail_in = '0;
    endtask

    task automatic test_credit_block();
        do_reset();
        req_in[0] = 1'b1; tail_in[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({grant_valid, grant_id} !== 5'b1_0000) begin errors++; $display("FAIL cb_grant%0d got v %0b id %0d exp v 1 id 0", i, grant_valid, grant_id); end
            tick();
            checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL cb_bubble%0d got %0b exp 0", i, grant_valid); end
        end
        checks++; if (credit_ok !== 2'b10) begin errors++; $display("FAIL cb_drained got %b exp 10", credit_ok); end
        tick();
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL cb_blocked got %0b exp 0", grant_valid); end
        credit_inc[0] = 1'b1;
        tick();
        credit_inc = '0;
        checks++; if (credit_ok !== 2'b11 || grant_valid !== 1'b0) begin errors++; $display("FAIL cb_returned got ok %b v %0b exp ok 11 v 0", credit_ok, grant_valid); end
        tick();
        checks++; if ({grant_valid, grant_id} !== 5'b1_0000) begin errors++; $display("FAIL cb_regrant got v %0b id %0d exp v 1 id 0", grant_valid, grant_id); end
        tick();
        checks++; if (credit_ok !== 2'b10 || grant_valid !== 1'b0) begin errors++; $display("FAIL cb_redrained got ok %b v %0b exp ok 10 v 0", credit_ok, grant_valid); end
        req_in = '0; tail_in = '0;
    endtask

    task automatic test_credit_same_cycle();
        do_reset();
        req_in[1] = 1'b1; tail_in[1] = 1'b1;
        tick(); tick(); tick(); tick();
        checks++; if (dut.g_vc[1].cnt_q !== 3'd2) begin errors++; $display("FAIL cs_pre got %0d exp 2", dut.g_vc[1].cnt_q); end
        tick();
        checks++; if (grant_id !== 4'd1 || xfer !== 1'b1) begin errors++; $display("FAIL cs_grant got id %0d x %0b exp id 1 x 1", grant_id, xfer); end
        credit_inc[1] = 1'b1;
        tick();
        checks++; if (dut.g_vc[1].cnt_q !== 3'd2) begin errors++; $display("FAIL cs_both got %0d exp 2", dut.g_vc[1].cnt_q); end
        req_in = '0; tail_in = '0;
        tick();
        checks++; if (dut.g_vc[1].cnt_q !== 3'd3) begin errors++; $display("FAIL cs_inc got %0d exp 3", dut.g_vc[1].cnt_q); end
        tick();
        checks++; if (dut.g_vc[1].cnt_q !== 3'd4) begin errors++; $display("FAIL cs_full got %0d exp 4", dut.g_vc[1].cnt_q); end
        tick();
        checks++; if (dut.g_vc[1].cnt_q !== 3'd4) begin errors++; $display("FAIL cs_saturate got %0d exp 4", dut.g_vc[1].cnt_q); end
        credit_inc = '0;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        req_in[4] = 1'b1; tail_in[4] = 1'b1;
        tick(); tick();
        checks++; if (dut.token_q !== 4'd5) begin errors++; $display("FAIL rm_token5 got %0d exp 5", dut.token_q); end
        req_in = '0; tail_in = '0;
        req_in[5] = 1'b1; req_in[2] = 1'b1; tail_in[2] = 1'b1;
        tick();
        checks++; if (grant_id !== 4'd5 || xfer !== 1'b1) begin errors++; $display("FAIL rm_grant5 got id %0d x %0b exp id 5 x 1", grant_id, xfer); end
        tick();
        checks++; if (grant_id !== 4'd5 || dut.g_vc[1].cnt_q !== 3'd3) begin errors++; $display("FAIL rm_hold5 got id %0d cnt %0d exp id 5 cnt 3", grant_id, dut.g_vc[1].cnt_q); end
        rst_p = 1'b1;
        #1;
        checks++; if (grant_valid !== 1'b0 || grant_id !== 4'd0 || xfer !== 1'b0) begin errors++; $display("FAIL rm_async got v %0b id %0d x %0b exp all 0", grant_valid, grant_id, xfer); end
        checks++; if (dut.g_vc[1].cnt_q !== 3'd4 || dut.g_vc[0].cnt_q !== 3'd4) begin errors++; $display("FAIL rm_credits got %0d %0d exp 4 4", dut.g_vc[0].cnt_q, dut.g_vc[1].cnt_q); end
        tick();
        rst_p = 1'b0;
        tick();
        checks++; if (grant_id !== 4'd2 || grant_valid !== 1'b1) begin errors++; $display("FAIL rm_token0 got id %0d v %0b exp id 2 v 1", grant_id, grant_valid); end
        tick();
        req_in = '0; tail_in = '0;
    endtask

    task automatic test_stuck_owner();
        do_reset();
        req_in[2] = 1'b1; tail_in[2] = 1'b0;
        tick();
        checks++; if (grant_id !== 4'd2) begin errors++; $display("FAIL so_grant got %0d exp 2", grant_id); end
        req_in = '0;
`ifdef VC_OUT_ALLOC_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++; if (grant_valid !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL so_wait%0d got v %0b t %0b exp v 1 t 0", i, grant_valid, timeout_err); end
        end
        tick();
        checks++; if (grant_valid !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL so_fire got v %0b t %0b exp v 0 t 1", grant_valid, timeout_err); end
        checks++; if (dut.token_q !== 4'd3) begin errors++; $display("FAIL so_token got %0d exp 3", dut.token_q); end
        tick();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL so_pulse got %0b exp 0", timeout_err); end
`else
        for (int i = 0; i < 20; i++) tick();
        checks++; if (grant_valid !== 1'b1 || grant_id !== 4'd2 || timeout_err !== 1'b0) begin errors++; $display("FAIL so_persist got v %0b id %0d t %0b exp v 1 id 2 t 0", grant_valid, grant_id, timeout_err); end
`endif
        do_reset();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wormhole();
        test_credit_block();
        test_credit_same_cycle();
        test_reset_mid_packet();
        test_stuck_owner();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
